// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the writeback path.
package cpu_pkg;
  localparam int XLEN = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_GPR = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_ALU,
    GNT_FIFO
  } grant_e;
endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO buffering load results ({wreg, wdata}) ahead of writeback.
module wb_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_data = mem[rd_ptr];

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU and buffered load results onto the single GPR
// write port, with starvation relief for loads and a busy scoreboard for issue.
module wb_arbiter #(
  parameter int XLEN = cpu_pkg::XLEN,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_LIMIT = 3,
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          alu_valid,
  input  logic [cpu_pkg::REG_ADDR_W-1:0] alu_wreg,
  input  logic [XLEN-1:0]               alu_wdata,
  output logic                          alu_stall,
  input  logic                          ld_valid,
  output logic                          ld_ready,
  input  logic [cpu_pkg::REG_ADDR_W-1:0] ld_wreg,
  input  logic [XLEN-1:0]               ld_wdata,
  input  logic                          iss_valid,
  input  logic [cpu_pkg::REG_ADDR_W-1:0] iss_wreg,
  output logic [cpu_pkg::NUM_GPR-1:0]   busy,
  output logic [cpu_pkg::REG_ADDR_W-1:0] wreg,
  output logic [XLEN-1:0]               wdata,
  output logic                          w_en,
  output logic [CNT_W-1:0]              fifo_count
);
  import cpu_pkg::*;

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam int ENTRY_W  = REG_ADDR_W + XLEN;

  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  push;
  logic                  pop;
  logic [ENTRY_W-1:0]    head_data;
  logic [REG_ADDR_W-1:0] head_wreg;
  logic [XLEN-1:0]       head_wdata;

  grant_e                grant;
  logic [REG_ADDR_W-1:0] sel_wreg;
  logic [XLEN-1:0]       sel_wdata;
  logic                  commit;
  logic [STARVE_W-1:0]   starve_cnt;
  logic [STARVE_W-1:0]   starve_next;
  logic                  stall_next;
  logic [NUM_GPR-1:0]    busy_next;

  assign ld_ready = !fifo_full;
  assign push     = ld_valid && ld_ready;
  assign {head_wreg, head_wdata} = head_data;

  wb_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_data ({ld_wreg, ld_wdata}),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    grant       = GNT_NONE;
    pop         = 1'b0;
    sel_wreg    = alu_wreg;
    sel_wdata   = alu_wdata;
    starve_next = starve_cnt;
    stall_next  = 1'b0;

    // A stall cycle only exists while the FIFO holds the entry that starved.
    if (alu_stall)        grant = GNT_FIFO;
    else if (alu_valid)   grant = GNT_ALU;
    else if (!fifo_empty) grant = GNT_FIFO;

    if (grant == GNT_FIFO) begin
      pop       = 1'b1;
      sel_wreg  = head_wreg;
      sel_wdata = head_wdata;
    end

    if (grant == GNT_ALU && !fifo_empty) begin
      if (starve_cnt == STARVE_W'(STARVE_LIMIT - 1)) begin
        starve_next = '0;
        stall_next  = 1'b1;
      end else begin
        starve_next = starve_cnt + 1'b1;
      end
    end else begin
      starve_next = '0;
    end

    commit = (grant != GNT_NONE) && (sel_wreg != REG_ZERO);

    // Clear on commit first so a same-edge issue to that register wins.
    busy_next = busy;
    if (commit) busy_next[sel_wreg] = 1'b0;
    if (iss_valid && iss_wreg != REG_ZERO) busy_next[iss_wreg] = 1'b1;
    busy_next[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
      alu_stall  <= 1'b0;
      w_en       <= 1'b0;
      wreg       <= '0;
      wdata      <= '0;
      busy       <= '0;
    end else begin
      starve_cnt <= starve_next;
      alu_stall  <= stall_next;
      w_en       <= commit;
      busy       <= busy_next;
      if (grant != GNT_NONE) begin
        wreg  <= sel_wreg;
        wdata <= sel_wdata;
      end
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: vector table, hand-written corner sequences, and a
// randomized run against a queue-based reference model.
module tb_wb_arbiter;
  localparam int XLEN = 32;
  localparam int FIFO_DEPTH = 4;
  localparam int STARVE_LIMIT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_wreg = '0;
  logic [31:0] alu_wdata = '0;
  logic        alu_stall;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [4:0]  ld_wreg = '0;
  logic [31:0] ld_wdata = '0;
  logic        iss_valid = 1'b0;
  logic [4:0]  iss_wreg = '0;
  logic [31:0] busy;
  logic [4:0]  wreg;
  logic [31:0] wdata;
  logic        w_en;
  logic [2:0]  fifo_count;

  int tests = 0;
  int fails = 0;

  wb_arbiter #(
    .XLEN(XLEN),
    .FIFO_DEPTH(FIFO_DEPTH),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_valid  (alu_valid),
    .alu_wreg   (alu_wreg),
    .alu_wdata  (alu_wdata),
    .alu_stall  (alu_stall),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_wreg    (ld_wreg),
    .ld_wdata   (ld_wdata),
    .iss_valid  (iss_valid),
    .iss_wreg   (iss_wreg),
    .busy       (busy),
    .wreg       (wreg),
    .wdata      (wdata),
    .w_en       (w_en),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  always @(negedge clk) begin
    if (!rst && alu_valid && alu_stall) begin
      fails++;
      $display("FAIL protocol: alu_valid asserted while alu_stall=1");
    end
  end

  typedef struct {
    logic        alu_v;
    logic [4:0]  alu_r;
    logic [31:0] alu_d;
    logic        iss_v;
    logic [4:0]  iss_r;
    logic        exp_wen;
    logic [4:0]  exp_wreg;
    logic [31:0] exp_wdata;
    logic [31:0] exp_busy;
  } vec_t;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } entry_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0;
    ld_valid  = 1'b0;
    iss_valid = 1'b0;
    alu_wreg  = '0;
    alu_wdata = '0;
    ld_wreg   = '0;
    ld_wdata  = '0;
    iss_wreg  = '0;
  endtask

  initial begin
    vec_t   vecs[9];
    entry_t mq[$];
    entry_t e;
    logic [31:0] m_busy;
    logic        m_stall, m_wen, nxt_stall, exp_ready, have, use_fifo, use_alu;
    logic [4:0]  m_wreg, wr, r;
    logic [31:0] m_wdata, wd;
    int          losses;

    //           alu_v  alu_r  alu_d          iss_v iss_r  wen   wreg   wdata          busy
    vecs[0] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd5, 1'b0, 5'd0,  32'h0,        32'h0000_0020};
    vecs[1] = '{1'b1, 5'd5,  32'h1234,     1'b0, 5'd0, 1'b1, 5'd5,  32'h1234,     32'h0000_0000};
    vecs[2] = '{1'b1, 5'd0,  32'hFFFF,     1'b1, 5'd0, 1'b0, 5'd0,  32'h0,        32'h0000_0000};
    vecs[3] = '{1'b1, 5'd9,  32'hAA,       1'b1, 5'd9, 1'b1, 5'd9,  32'hAA,       32'h0000_0200};
    vecs[4] = '{1'b1, 5'd9,  32'hBB,       1'b0, 5'd0, 1'b1, 5'd9,  32'hBB,       32'h0000_0000};
    vecs[5] = '{1'b1, 5'd31, 32'hFFFF_FFFF,1'b1, 5'd1, 1'b1, 5'd31, 32'hFFFF_FFFF,32'h0000_0002};
    vecs[6] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd2, 1'b0, 5'd0,  32'h0,        32'h0000_0006};
    vecs[7] = '{1'b1, 5'd2,  32'h1,        1'b0, 5'd0, 1'b1, 5'd2,  32'h1,        32'h0000_0002};
    vecs[8] = '{1'b1, 5'd1,  32'h2,        1'b0, 5'd0, 1'b1, 5'd1,  32'h2,        32'h0000_0000};

    // Reset state
    #1;
    check("rst_count", fifo_count, 0);
    check("rst_busy", busy, 0);
    check("rst_w_en", w_en, 0);
    check("rst_wreg", wreg, 0);
    check("rst_wdata", wdata, 0);
    check("rst_alu_stall", alu_stall, 0);
    tick();
    tick();
    rst = 1'b0;
    check("rst_ld_ready", ld_ready, 1);

    // Vector table: ALU-only traffic and scoreboard corners
    for (int i = 0; i < 9; i++) begin
      alu_valid = vecs[i].alu_v;
      alu_wreg  = vecs[i].alu_r;
      alu_wdata = vecs[i].alu_d;
      iss_valid = vecs[i].iss_v;
      iss_wreg  = vecs[i].iss_r;
      tick();
      check($sformatf("vec%0d_w_en", i), w_en, vecs[i].exp_wen);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
      check($sformatf("vec%0d_alu_stall", i), alu_stall, 0);
      if (vecs[i].exp_wen) begin
        check($sformatf("vec%0d_wreg", i), wreg, vecs[i].exp_wreg);
        check($sformatf("vec%0d_wdata", i), wdata, vecs[i].exp_wdata);
      end
    end
    idle_inputs();
    tick();

    // Single load with ALU idle: written two edges after it is offered
    ld_valid = 1'b1; ld_wreg = 5'd7; ld_wdata = 32'hDEAD_BEEF;
    check("ld1_ready", ld_ready, 1);
    tick();
    idle_inputs();
    check("ld1_count_after_push", fifo_count, 1);
    check("ld1_w_en_early", w_en, 0);
    tick();
    check("ld1_w_en", w_en, 1);
    check("ld1_wreg", wreg, 7);
    check("ld1_wdata", wdata, 32'hDEAD_BEEF);
    check("ld1_count_after_pop", fifo_count, 0);

    // Starvation: ALU wins three times, then a one-cycle stall drains r8
    ld_valid = 1'b1; ld_wreg = 5'd8; ld_wdata = 32'h88;
    alu_valid = 1'b1; alu_wreg = 5'd10; alu_wdata = 32'h10;
    tick();
    ld_valid = 1'b0;
    check("starve_push_count", fifo_count, 1);
    check("starve_alu0_wreg", wreg, 10);
    for (int i = 0; i < 3; i++) begin
      alu_wreg = 5'(11 + i); alu_wdata = 32'(11 + i);
      tick();
      check($sformatf("starve_alu%0d_wreg", i + 1), wreg, 11 + i);
      check($sformatf("starve_stall%0d", i + 1), alu_stall, (i == 2) ? 1 : 0);
      check($sformatf("starve_count%0d", i + 1), fifo_count, 1);
    end
    alu_valid = 1'b0;
    tick();
    check("starve_ld_w_en", w_en, 1);
    check("starve_ld_wreg", wreg, 8);
    check("starve_ld_wdata", wdata, 32'h88);
    check("starve_stall_drop", alu_stall, 0);
    check("starve_count_end", fifo_count, 0);
    idle_inputs();

    // Fill FIFO to capacity under ALU pressure, then drain in order
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1; ld_wreg = 5'(i + 1); ld_wdata = 32'h100 + 32'(i);
      alu_valid = 1'b1; alu_wreg = 5'(20 + i); alu_wdata = 32'(i);
      tick();
    end
    check("full_count", fifo_count, 4);
    check("full_ld_ready", ld_ready, 0);
    check("full_stall", alu_stall, 1);
    alu_valid = 1'b0;
    ld_valid = 1'b1; ld_wreg = 5'd5; ld_wdata = 32'h555;
    check("full_ld_ready_held", ld_ready, 0);
    tick();
    ld_valid = 1'b0;
    check("full_nopush_count", fifo_count, 3);
    check("drain1_wreg", wreg, 1);
    check("drain1_w_en", w_en, 1);
    for (int k = 2; k <= 4; k++) begin
      tick();
      check($sformatf("drain%0d_w_en", k), w_en, 1);
      check($sformatf("drain%0d_wreg", k), wreg, k);
      check($sformatf("drain%0d_wdata", k), wdata, 32'h100 + 32'(k - 1));
    end
    check("drain_count_end", fifo_count, 0);
    idle_inputs();
    tick();

    // Reset mid-run with three buffered loads and two busy registers
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1; ld_wreg = 5'(i + 1); ld_wdata = 32'h11 * 32'(i + 1);
      alu_valid = 1'b1; alu_wreg = 5'd3; alu_wdata = 32'h33;
      iss_valid = (i < 2); iss_wreg = (i == 0) ? 5'd4 : 5'd8;
      tick();
    end
    idle_inputs();
    check("mid_setup_count", fifo_count, 3);
    check("mid_setup_busy", busy, 32'h0000_0110);
    #3;
    rst = 1'b1;
    #1;
    check("mid_rst_count", fifo_count, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_w_en", w_en, 0);
    check("mid_rst_stall", alu_stall, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_ld_ready", ld_ready, 1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("mid_rst_stale%0d", i), w_en, 0);
    end

    // Randomized run against a queue-based model starting from reset state
    m_busy = '0; m_stall = 1'b0; m_wen = 1'b0; m_wreg = '0; m_wdata = '0; losses = 0;
    for (int n = 0; n < 400; n++) begin
      alu_valid = !m_stall && ($urandom % 3 != 0);
      alu_wreg  = 5'($urandom % 32);
      alu_wdata = $urandom;
      ld_valid  = (n < 200) ? ($urandom % 3 != 0) : ($urandom % 4 == 0);
      ld_wreg   = 5'($urandom % 32);
      ld_wdata  = $urandom;
      r = 5'($urandom_range(1, 31));
      if ($urandom % 16 == 0) begin
        iss_valid = 1'b1; iss_wreg = 5'd0;
      end else begin
        iss_valid = !m_busy[r] && ($urandom % 3 == 0);
        iss_wreg  = r;
      end

      exp_ready = (mq.size() < FIFO_DEPTH);
      check("rnd_ld_ready", ld_ready, exp_ready);

      have     = (mq.size() > 0);
      use_fifo = m_stall || (!alu_valid && have);
      use_alu  = !m_stall && alu_valid;
      if (use_fifo) begin
        e  = mq.pop_front();
        wr = e.r; wd = e.d;
      end else begin
        wr = alu_wreg; wd = alu_wdata;
      end
      m_wen = (use_fifo || use_alu) && (wr != 5'd0);
      if (m_wen) begin
        m_wreg = wr; m_wdata = wd;
      end

      nxt_stall = 1'b0;
      if (use_alu && have) begin
        losses++;
        if (losses == STARVE_LIMIT) begin
          nxt_stall = 1'b1;
          losses = 0;
        end
      end else begin
        losses = 0;
      end
      m_stall = nxt_stall;

      if (ld_valid && exp_ready) mq.push_back('{ld_wreg, ld_wdata});
      if (m_wen) m_busy[wr] = 1'b0;
      if (iss_valid && iss_wreg != 5'd0) m_busy[iss_wreg] = 1'b1;

      tick();
      check("rnd_w_en", w_en, m_wen);
      check("rnd_busy", busy, m_busy);
      check("rnd_alu_stall", alu_stall, m_stall);
      check("rnd_count", fifo_count, mq.size());
      if (m_wen) begin
        check("rnd_wreg", wreg, m_wreg);
        check("rnd_wdata", wdata, m_wdata);
      end
    end
    idle_inputs();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
